da_fir_sequencer: RTL and testbench
===================================

Name: da_fir_sequencer

Overview:
- Sequences one distributed-arithmetic FIR output per accepted input sample, using the 64-tap sample FIFO and its bit-serial shift-register bank.
- Per sample, in order: shift the sample into the FIFO, snapshot the FIFO into the shift registers, clock WIDTH bit-slices MSB-first, then shift-accumulate the LUT/adder-tree partial sums into a signed result.
- Sits between the sample source and the FIFO/LUT datapath; it owns all load, shift and accumulate timing.

Parameters:
NTAPS, 64, taps in FIFO (also prime-count limit)
WIDTH, 16, sample width = number of bit-slices per output
PSUM_W, 24, signed partial-sum width from LUT adder tree
LUT_LAT, 2, cycles from slice address at shift-reg outputs to psum_in valid (1..4)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
sample_in  in  WIDTH  input sample (two's complement)
sample_valid  in  1  sample offered
sample_ready  out  1  sequencer can accept a sample
fifo_din  out  WIDTH  registered sample to FIFO write port
fifo_shift  out  1  FIFO shift enable, one-cycle pulse
sreg_load  out  1  shift-register bank parallel load, one-cycle pulse
sreg_shift  out  1  shift-register bank shift enable
psum_in  in  PSUM_W  signed partial sum for current slice
y_out  out  PSUM_W+WIDTH  signed filter output
y_valid  out  1  y_out valid; held until y_ready
y_ready  in  1  consumer accepts y_out
primed  out  1  at least NTAPS samples shifted since reset
busy  out  1  state != IDLE

Behaviour:
- Reset (sync, active-high) forces state IDLE. Reset values: bit_cnt=0, drain_cnt=0, acc=0, y_out=0, fifo_din=0, prime_cnt=0, tag delay line cleared. All control outputs 0 except sample_ready=1.
- Reset mid-operation abandons the computation. No stale psum may be accumulated after reset deasserts.
- All outputs are registered or decoded purely from state. There are no combinational paths from inputs to outputs.
- States and transitions:
  - IDLE: sample_ready=1. When sample_valid=1, capture fifo_din<=sample_in and go to SHIFT.
  - SHIFT: fifo_shift=1 for 1 cycle. Increment prime_cnt, saturating at NTAPS. Go to LOAD.
  - LOAD: sreg_load=1 for 1 cycle; bit_cnt<=0. Go to RUN.
  - RUN: WIDTH cycles. In RUN cycle k (k=0..WIDTH-1), slice k (k=0 is the sample MSB) is at the shift-reg outputs. sreg_shift=1 in cycles k=0..WIDTH-2 and 0 in the last cycle. A tag {valid, first=(k==0)} enters a LUT_LAT-deep delay line. After bit_cnt==WIDTH-1, go to DRAIN.
  - DRAIN: LUT_LAT cycles, counted by drain_cnt. Then go to OUT.
  - OUT: y_valid=1, y_out stable. When y_ready=1, go to IDLE; y_valid drops the next cycle.
- Accumulator: acts when the delayed tag is valid.
  - first=1 (sign slice): acc <= -sext(psum_in).
  - first=0: acc <= (acc<<1) + sext(psum_in).
  - acc width is PSUM_W+WIDTH. No saturation; wraps modulo 2^(PSUM_W+WIDTH).
- y_out is loaded from acc on the DRAIN->OUT transition and holds until the next such load.
- Latency: sample accepted at cycle t0 -> y_valid first high at t0+19+LUT_LAT (t0+21 at default).
  - Minimum period between accepts is 22+LUT_LAT-2 cycles when y_ready is high.
  - y_ready low stalls in OUT indefinitely; sample_ready stays 0 throughout.
- sample_valid while not IDLE: ignored. The source must hold the sample.
- y_valid is produced regardless of primed. primed is an advisory output; primed=1 from the cycle after the NTAPS-th SHIFT.
- sample_valid and y_ready arriving together in OUT: y_ready is honoured. The sample is accepted only in the following IDLE cycle.

Decomposition:
- Shared package da_fir_pkg holds:
  - state enum (IDLE, SHIFT, LOAD, RUN, DRAIN, OUT)
  - constants NTAPS, WIDTH, PSUM_W, ACC_W=PSUM_W+WIDTH
  - default LUT_LAT
- One natural sub-module, da_accumulator: tag delay line plus signed shift-accumulate with sign-slice negation.
- The FSM and counters stay in the top module.

Test Plan:
- Reset mid-RUN (assert reset at RUN k=7), then psum_in=7 constantly: next cycle state IDLE, busy=0, sample_ready=1, y_out=0; no y_valid in the following 30 cycles.
- sample_in=0x1234 accepted at t0: fifo_shift at t0+1, sreg_load at t0+2, sreg_shift high t0+3..t0+17 (15 cycles) and low at t0+18, y_valid at t0+21; fifo_din=0x1234.
- psum_in=1 on every slice -> y_out = -1. psum_in=5 only on slice 15 -> y_out = 5. psum_in=3 only on slice 0 -> y_out = -98304.
- Hold y_ready=0 for 10 cycles after y_valid: y_valid and y_out stable, sample_ready=0, second sample_valid not accepted; y_ready=1 -> IDLE, second sample accepted the next cycle.
- Stream 64 samples back-to-back with y_ready=1: primed=0 through the 63rd SHIFT, 1 after the 64th; accept period exactly 22 cycles.

Source files
------------

// File: rtl/da_fir_pkg.sv
// Shared types and constants for the distributed-arithmetic FIR sequencer.
package da_fir_pkg;
  localparam int NTAPS       = 64;
  localparam int WIDTH       = 16;
  localparam int PSUM_W      = 24;
  localparam int ACC_W       = PSUM_W + WIDTH;
  localparam int DEF_LUT_LAT = 2;
  localparam int PRIME_W     = $clog2(NTAPS + 1);
  localparam int BIT_W       = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, SHIFT, LOAD, RUN, DRAIN, OUT} state_e;

  // Travels alongside each bit-slice until its partial sum comes back
  typedef struct packed {
    logic vld;
    logic first;
  } tag_t;
endpackage

// File: rtl/da_fir_sequencer_if.sv
// Sample source / FIFO-LUT datapath / result consumer bundle around the sequencer.
interface da_fir_sequencer_if;
  import da_fir_pkg::*;

  logic        [WIDTH-1:0]  sample_in;
  logic                     sample_valid;
  logic                     sample_ready;
  logic        [WIDTH-1:0]  fifo_din;
  logic                     fifo_shift;
  logic                     sreg_load;
  logic                     sreg_shift;
  logic signed [PSUM_W-1:0] psum_in;
  logic signed [ACC_W-1:0]  y_out;
  logic                     y_valid;
  logic                     y_ready;
  logic                     primed;
  logic                     busy;

  modport master (
    input  sample_in, sample_valid, psum_in, y_ready,
    output sample_ready, fifo_din, fifo_shift, sreg_load, sreg_shift,
           y_out, y_valid, primed, busy
  );

  modport slave (
    output sample_in, sample_valid, psum_in, y_ready,
    input  sample_ready, fifo_din, fifo_shift, sreg_load, sreg_shift,
           y_out, y_valid, primed, busy
  );
endinterface

// File: rtl/da_accumulator.sv
// Tag delay line matching LUT latency plus signed shift-accumulate of partial sums.
module da_accumulator
  import da_fir_pkg::*;
#(
  parameter int LUT_LAT = DEF_LUT_LAT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  tag_t                     tag_in,
  input  logic signed [PSUM_W-1:0] psum_in,
  output logic signed [ACC_W-1:0]  acc_next
);
  tag_t [LUT_LAT-1:0]      tag_pipe_q, tag_pipe_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] psum_ext;
  tag_t                    tag_dly;

  assign psum_ext = {{WIDTH{psum_in[PSUM_W-1]}}, psum_in};
  assign tag_dly  = tag_pipe_q[LUT_LAT-1];
  assign acc_next = acc_d;

  always_comb begin
    tag_pipe_d[0] = tag_in;
    for (int i = 1; i < LUT_LAT; i++) tag_pipe_d[i] = tag_pipe_q[i-1];
  end

  // The MSB slice carries negative weight in two's complement, hence the negation
  always_comb begin
    acc_d = acc_q;
    if (tag_dly.vld) begin
      if (tag_dly.first) acc_d = -psum_ext;
      else               acc_d = (acc_q <<< 1) + psum_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_pipe_q <= '0;
      acc_q      <= '0;
    end else begin
      tag_pipe_q <= tag_pipe_d;
      acc_q      <= acc_d;
    end
  end
endmodule

// File: rtl/da_fir_sequencer.sv
// Per-sample load / bit-serial shift / accumulate sequencer for a DA FIR.
module da_fir_sequencer
  import da_fir_pkg::*;
#(
  parameter int LUT_LAT = DEF_LUT_LAT
) (
  input  logic         clk,
  input  logic         reset,
  da_fir_sequencer_if.master bus
);
  localparam int DRAIN_W = (LUT_LAT > 1) ? $clog2(LUT_LAT) : 1;

  state_e               state_q, state_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic [PRIME_W-1:0]   prime_cnt_q, prime_cnt_d;
  logic [WIDTH-1:0]     fifo_din_q, fifo_din_d;
  logic signed [ACC_W-1:0] y_out_q, y_out_d;
  logic sample_ready_q, sample_ready_d;
  logic fifo_shift_q, fifo_shift_d;
  logic sreg_load_q, sreg_load_d;
  logic sreg_shift_q, sreg_shift_d;
  logic y_valid_q, y_valid_d;
  logic busy_q, busy_d;
  logic primed_q, primed_d;
  logic signed [ACC_W-1:0] acc_next;
  tag_t tag_in;

  assign tag_in.vld   = (state_q == RUN);
  assign tag_in.first = (bit_cnt_q == '0);

  da_accumulator #(.LUT_LAT(LUT_LAT)) u_acc (
    .clk      (clk),
    .reset    (reset),
    .tag_in   (tag_in),
    .psum_in  (bus.psum_in),
    .acc_next (acc_next)
  );

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    drain_cnt_d = drain_cnt_q;
    prime_cnt_d = prime_cnt_q;
    fifo_din_d  = fifo_din_q;
    y_out_d     = y_out_q;
    case (state_q)
      IDLE: if (bus.sample_valid) begin
        fifo_din_d = bus.sample_in;
        state_d    = SHIFT;
      end
      SHIFT: begin
        if (prime_cnt_q != PRIME_W'(NTAPS)) prime_cnt_d = prime_cnt_q + PRIME_W'(1);
        state_d = LOAD;
      end
      LOAD: begin
        bit_cnt_d = '0;
        state_d   = RUN;
      end
      RUN: begin
        if (bit_cnt_q == BIT_W'(WIDTH - 1)) begin
          bit_cnt_d   = '0;
          drain_cnt_d = '0;
          state_d     = DRAIN;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end
      // The last slice's psum lands in the final drain cycle, so take the
      // accumulator's next value rather than its registered one
      DRAIN: begin
        if (drain_cnt_q == DRAIN_W'(LUT_LAT - 1)) begin
          y_out_d = acc_next;
          state_d = OUT;
        end else begin
          drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
        end
      end
      OUT: if (bus.y_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    sample_ready_d = (state_d == IDLE);
    fifo_shift_d   = (state_d == SHIFT);
    sreg_load_d    = (state_d == LOAD);
    sreg_shift_d   = (state_d == RUN) && (bit_cnt_d != BIT_W'(WIDTH - 1));
    y_valid_d      = (state_d == OUT);
    busy_d         = (state_d != IDLE);
    primed_d       = (prime_cnt_d == PRIME_W'(NTAPS));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      drain_cnt_q    <= '0;
      prime_cnt_q    <= '0;
      fifo_din_q     <= '0;
      y_out_q        <= '0;
      sample_ready_q <= 1'b1;
      fifo_shift_q   <= 1'b0;
      sreg_load_q    <= 1'b0;
      sreg_shift_q   <= 1'b0;
      y_valid_q      <= 1'b0;
      busy_q         <= 1'b0;
      primed_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      drain_cnt_q    <= drain_cnt_d;
      prime_cnt_q    <= prime_cnt_d;
      fifo_din_q     <= fifo_din_d;
      y_out_q        <= y_out_d;
      sample_ready_q <= sample_ready_d;
      fifo_shift_q   <= fifo_shift_d;
      sreg_load_q    <= sreg_load_d;
      sreg_shift_q   <= sreg_shift_d;
      y_valid_q      <= y_valid_d;
      busy_q         <= busy_d;
      primed_q       <= primed_d;
    end
  end

  assign bus.sample_ready = sample_ready_q;
  assign bus.fifo_din     = fifo_din_q;
  assign bus.fifo_shift   = fifo_shift_q;
  assign bus.sreg_load    = sreg_load_q;
  assign bus.sreg_shift   = sreg_shift_q;
  assign bus.y_out        = y_out_q;
  assign bus.y_valid      = y_valid_q;
  assign bus.busy         = busy_q;
  assign bus.primed       = primed_q;
endmodule

// File: tb/tb_da_fir_sequencer.sv
// Directed + randomized bench for da_fir_sequencer against a weighted-sum DA model.
module tb_da_fir_sequencer;
  import da_fir_pkg::*;

  localparam int LAT  = DEF_LUT_LAT;
  localparam int LAST = 19 + LAT;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_t0 = 0;
  bit   chain = 1'b0;
  int   nshift = 0;

  da_fir_sequencer_if bus();

  da_fir_sequencer #(.LUT_LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {63'd0, obs}, {63'd0, exp});
  endtask

  function automatic logic [63:0] yx(input logic [ACC_W-1:0] v);
    return {{(64-ACC_W){1'b0}}, v};
  endfunction

  // mode: 0 random psums, 1 all ones, 2 only last slice = 5, 3 only sign slice = 3
  task automatic do_sample(input logic [WIDTH-1:0] s, input int mode, input int stall,
                           input bit keep);
    logic signed [PSUM_W-1:0] ps [WIDTH];
    longint y;
    logic [ACC_W-1:0] y_ref;
    int k;
    for (int i = 0; i < WIDTH; i++) begin
      case (mode)
        1:       ps[i] = PSUM_W'(1);
        2:       ps[i] = (i == WIDTH-1) ? PSUM_W'(5) : PSUM_W'(0);
        3:       ps[i] = (i == 0) ? PSUM_W'(3) : PSUM_W'(0);
        default: ps[i] = PSUM_W'($urandom);
      endcase
    end
    // Output = sum of slice partial sums weighted by bit significance, MSB negative
    y = 0;
    for (int i = 0; i < WIDTH; i++) begin
      longint w;
      w = longint'(1) <<< (WIDTH - 1 - i);
      if (i == 0) w = -w;
      y += w * longint'(ps[i]);
    end
    y_ref = y[ACC_W-1:0];

    chk1("ready_at_accept", bus.sample_ready, 1'b1);
    if (chain) chk("accept_period", 64'(cyc - last_t0), 64'(22 + LAT - 2));
    last_t0 = cyc;
    bus.sample_valid = 1'b1;
    bus.sample_in    = s;
    bus.y_ready      = 1'b0;
    bus.psum_in      = PSUM_W'($urandom);

    for (int c = 1; c <= LAST; c++) begin
      tick();
      bus.sample_in = WIDTH'($urandom);
      k = c - 3 - LAT;
      bus.psum_in = (k >= 0 && k < WIDTH) ? ps[k] : PSUM_W'($urandom);
      chk1("fifo_shift", bus.fifo_shift, c == 1);
      chk1("sreg_load", bus.sreg_load, c == 2);
      chk1("sreg_shift", bus.sreg_shift, (c >= 3) && (c <= WIDTH + 1));
      chk1("y_valid", bus.y_valid, c == LAST);
      chk1("sample_ready_busy", bus.sample_ready, 1'b0);
      chk1("busy", bus.busy, 1'b1);
      if (c == 1) begin
        chk("fifo_din", 64'(bus.fifo_din), 64'(s));
        chk1("primed_pre", bus.primed, nshift >= NTAPS);
        nshift++;
      end
      if (c == 2) chk1("primed_post", bus.primed, nshift >= NTAPS);
    end
    chk("y_out", yx(bus.y_out), yx(y_ref));
    chk("fifo_din_hold", 64'(bus.fifo_din), 64'(s));

    for (int i = 0; i < stall; i++) begin
      tick();
      bus.psum_in = PSUM_W'($urandom);
      chk1("stall_y_valid", bus.y_valid, 1'b1);
      chk("stall_y_out", yx(bus.y_out), yx(y_ref));
      chk1("stall_ready", bus.sample_ready, 1'b0);
    end
    bus.y_ready      = 1'b1;
    bus.sample_valid = keep;
    tick();
    bus.y_ready = 1'b0;
    bus.psum_in = PSUM_W'($urandom);
    chk1("y_valid_drop", bus.y_valid, 1'b0);
    chk1("ready_back", bus.sample_ready, 1'b1);
    chk1("busy_drop", bus.busy, 1'b0);
    chain = keep && (stall == 0);
  endtask

  initial begin
    bus.sample_in    = '0;
    bus.sample_valid = 1'b0;
    bus.psum_in      = '0;
    bus.y_ready      = 1'b0;
    reset            = 1'b1;
    repeat (3) tick();
    chk1("rst_ready", bus.sample_ready, 1'b1);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_y_valid", bus.y_valid, 1'b0);
    chk1("rst_fifo_shift", bus.fifo_shift, 1'b0);
    chk1("rst_sreg_load", bus.sreg_load, 1'b0);
    chk1("rst_sreg_shift", bus.sreg_shift, 1'b0);
    chk1("rst_primed", bus.primed, 1'b0);
    chk("rst_y_out", yx(bus.y_out), 64'd0);
    chk("rst_fifo_din", 64'(bus.fifo_din), 64'd0);
    reset = 1'b0;
    tick();
    chk1("idle_ready", bus.sample_ready, 1'b1);

    do_sample(16'h1234, 0, 0, 1'b0);
    do_sample(WIDTH'($urandom), 1, 0, 1'b0);
    do_sample(WIDTH'($urandom), 2, 0, 1'b0);
    do_sample(WIDTH'($urandom), 3, 0, 1'b0);
    do_sample(WIDTH'($urandom), 0, 10, 1'b1);
    do_sample(WIDTH'($urandom), 0, 0, 1'b0);

    // Abandon a computation at RUN slice 7; pending psums must not reach y_out
    bus.sample_valid = 1'b1;
    bus.sample_in    = WIDTH'($urandom);
    for (int c = 1; c <= 10; c++) tick();
    chk1("pre_reset_shift", bus.sreg_shift, 1'b1);
    reset            = 1'b1;
    bus.sample_valid = 1'b0;
    bus.psum_in      = PSUM_W'(7);
    tick();
    reset = 1'b0;
    chk1("mid_rst_busy", bus.busy, 1'b0);
    chk1("mid_rst_ready", bus.sample_ready, 1'b1);
    chk("mid_rst_y_out", yx(bus.y_out), 64'd0);
    chk1("mid_rst_sreg_shift", bus.sreg_shift, 1'b0);
    chk1("mid_rst_primed", bus.primed, 1'b0);
    nshift = 0;
    chain  = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk1("post_rst_y_valid", bus.y_valid, 1'b0);
      chk1("post_rst_busy", bus.busy, 1'b0);
    end
    chk("post_rst_y_out", yx(bus.y_out), 64'd0);

    for (int i = 0; i < NTAPS + 1; i++)
      do_sample(WIDTH'($urandom), 0, 0, i < NTAPS);

    for (int i = 0; i < 4; i++)
      do_sample(WIDTH'($urandom), 0, int'($urandom_range(0, 3)), 1'b0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
